// File: rtl/jtkunio_pkg.sv
// Shared definitions for the kunio SDRAM ROM read slots.
package jtkunio_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WACK = 2'd1,
        ST_WRDY = 2'd2
    } slot_state_t;

endpackage

// File: rtl/jtkunio_romslot.sv
// Single-word cached SDRAM read slot in front of a CPU ROM byte interface.
// One outstanding request at most; hits on the cached word cost no SDRAM traffic.
module jtkunio_romslot
    import jtkunio_pkg::*;
#(
    parameter int                    AW     = 16,
    parameter logic [SDRAM_AW-1:0]   OFFSET = 22'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 downloading,
    input  logic                 rom_cs,
    input  logic [AW-1:0]        rom_addr,
    output logic [7:0]           rom_data,
    output logic                 rom_ok,
    output logic [SDRAM_AW-1:0]  sdram_addr,
    output logic                 sdram_rd,
    input  logic                 sdram_ack,
    input  logic                 sdram_rdy,
    input  logic [15:0]          data_read
);

    slot_state_t          state_q, state_d;
    logic                 valid_q, valid_d;
    logic [AW-2:0]        tag_q, tag_d;
    logic [AW-2:0]        pend_tag_q, pend_tag_d;
    logic [15:0]          word_q, word_d;
    logic [SDRAM_AW-1:0]  sdram_addr_q, sdram_addr_d;
    logic                 sdram_rd_q, sdram_rd_d;
    logic                 dl_seen_q, dl_seen_d;
    logic                 hit;
    logic                 capture;

    assign hit        = valid_q & (tag_q == rom_addr[AW-1:1]);
    assign rom_ok     = rom_cs & hit & ~downloading;
    assign rom_data   = rom_addr[0] ? word_q[15:8] : word_q[7:0];
    assign sdram_addr = sdram_addr_q;
    assign sdram_rd   = sdram_rd_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        pend_tag_d   = pend_tag_q;
        word_d       = word_q;
        sdram_addr_d = sdram_addr_q;
        sdram_rd_d   = sdram_rd_q;
        capture      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rom_cs & ~hit & ~downloading) begin
                    sdram_addr_d = OFFSET + SDRAM_AW'(rom_addr[AW-1:1]);
                    pend_tag_d   = rom_addr[AW-1:1];
                    sdram_rd_d   = 1'b1;
                    state_d      = ST_WACK;
                end
            end
            ST_WACK: begin
                if (sdram_ack) begin
                    sdram_rd_d = 1'b0;
                    // rdy alongside ack completes the whole handshake at once
                    if (sdram_rdy) begin
                        capture = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WRDY;
                    end
                end
            end
            ST_WRDY: begin
                if (sdram_rdy) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sdram_rd_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        if (capture) begin
            word_d  = data_read;
            tag_d   = pend_tag_q;
            valid_d = ~dl_seen_q;
        end

        // A download may rewrite the ROM under us: never trust the cached word.
        if (downloading)
            valid_d = 1'b0;

        if (downloading)
            dl_seen_d = 1'b1;
        else if (state_q == ST_IDLE)
            dl_seen_d = 1'b0;
        else
            dl_seen_d = dl_seen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            tag_q        <= '0;
            pend_tag_q   <= '0;
            word_q       <= '0;
            sdram_addr_q <= '0;
            sdram_rd_q   <= 1'b0;
            dl_seen_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            pend_tag_q   <= pend_tag_d;
            word_q       <= word_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_rd_q   <= sdram_rd_d;
            dl_seen_q    <= dl_seen_d;
        end
    end

endmodule
